// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker state encoding, width limits and the XNOR
// Fibonacci next-state function used by both the PRBS generator and checker.
package lfsr_pkg;

  localparam int LFSR_MIN_BITS = 3;
  localparam int LFSR_MAX_BITS = 32;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  function automatic logic [LFSR_MAX_BITS-1:0] tap(input int n);
    return 32'd1 << (n - 1);
  endfunction

  // Maximal-length tap sets, 1-based bit numbers.
  function automatic logic [LFSR_MAX_BITS-1:0] lfsr_taps(input int width);
    logic [LFSR_MAX_BITS-1:0] t;
    case (width)
      3:       t = tap(3)  | tap(2);
      4:       t = tap(4)  | tap(3);
      5:       t = tap(5)  | tap(3);
      6:       t = tap(6)  | tap(5);
      7:       t = tap(7)  | tap(6);
      8:       t = tap(8)  | tap(6)  | tap(5)  | tap(4);
      9:       t = tap(9)  | tap(5);
      10:      t = tap(10) | tap(7);
      11:      t = tap(11) | tap(9);
      12:      t = tap(12) | tap(6)  | tap(4)  | tap(1);
      13:      t = tap(13) | tap(4)  | tap(3)  | tap(1);
      14:      t = tap(14) | tap(5)  | tap(3)  | tap(1);
      15:      t = tap(15) | tap(14);
      16:      t = tap(16) | tap(15) | tap(13) | tap(4);
      17:      t = tap(17) | tap(14);
      18:      t = tap(18) | tap(11);
      19:      t = tap(19) | tap(6)  | tap(2)  | tap(1);
      20:      t = tap(20) | tap(17);
      21:      t = tap(21) | tap(19);
      22:      t = tap(22) | tap(21);
      23:      t = tap(23) | tap(18);
      24:      t = tap(24) | tap(23) | tap(22) | tap(17);
      25:      t = tap(25) | tap(22);
      26:      t = tap(26) | tap(6)  | tap(2)  | tap(1);
      27:      t = tap(27) | tap(5)  | tap(2)  | tap(1);
      28:      t = tap(28) | tap(25);
      29:      t = tap(29) | tap(27);
      30:      t = tap(30) | tap(6)  | tap(4)  | tap(1);
      31:      t = tap(31) | tap(28);
      32:      t = tap(32) | tap(22) | tap(2)  | tap(1);
      default: t = 32'd0;
    endcase
    return t;
  endfunction

  // next(x) = {x[width-2:0], f}, f = left-associative XNOR chain from the top tap down.
  function automatic logic [LFSR_MAX_BITS-1:0] lfsr_next(
    input int                       width,
    input logic [LFSR_MAX_BITS-1:0] x
  );
    logic [LFSR_MAX_BITS-1:0] taps;
    logic [LFSR_MAX_BITS:0]   span;
    logic                     f;
    logic                     seen;
    taps = lfsr_taps(width);
    f    = 1'b0;
    seen = 1'b0;
    for (int i = LFSR_MAX_BITS - 1; i >= 0; i--) begin
      if (taps[i]) begin
        if (seen) begin
          f = ~(f ^ x[i]);
        end else begin
          f = x[i];
        end
        seen = 1'b1;
      end
    end
    span = (33'd1 << width) - 33'd1;
    return {x[LFSR_MAX_BITS-2:0], f} & span[LFSR_MAX_BITS-1:0];
  endfunction

endpackage

// File: rtl/lfsr_chk_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module lfsr_chk_counter
  import lfsr_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Clr,
  input  logic         i_Inc,
  output logic [W-1:0] o_Count
);

  logic [W-1:0] count_r;

  // Count register: reset/clear to zero, otherwise increment until all-ones.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      count_r <= '0;
    end else if (i_Clr) begin
      count_r <= '0;
    end else if (i_Inc && (count_r != '1)) begin
      count_r <= count_r + W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign o_Count = count_r;

endmodule

// File: rtl/lfsr_checker.sv
// PRBS receive checker: self-seeds from incoming words, locks after a run of
// correct predictions, then free-runs and counts mismatches.
// Optional period tracking outputs are built when LFSR_CHK_PERIOD_EN is defined.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS     = 32,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int CNT_W        = 16
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Data_DV,
  input  logic [NUM_BITS-1:0] i_Data,
  input  logic                i_Clr_Count,
  output logic                o_Locked,
  output logic                o_Error,
  output logic [CNT_W-1:0]    o_Err_Count,
`ifdef LFSR_CHK_PERIOD_EN
  output logic [NUM_BITS-1:0] o_Word_Count,
  output logic                o_Period_Done,
`endif
  output logic [NUM_BITS-1:0] o_Expected
);

  localparam int MR_W = $clog2(LOCK_COUNT + 1);
  localparam int MM_W = $clog2(UNLOCK_COUNT + 1);
  localparam logic [MR_W-1:0] LOCK_TGT   = MR_W'(LOCK_COUNT);
  localparam logic [MM_W-1:0] UNLOCK_TGT = MM_W'(UNLOCK_COUNT);

  chk_state_e               state_r;
  chk_state_e               state_nxt_s;
  logic [NUM_BITS-1:0]      expected_r;
  logic [NUM_BITS-1:0]      expected_nxt_s;
  logic [MR_W-1:0]          match_run_r;
  logic [MR_W-1:0]          match_run_nxt_s;
  logic [MR_W-1:0]          match_run_inc_s;
  logic [MM_W-1:0]          miss_run_r;
  logic [MM_W-1:0]          miss_run_nxt_s;
  logic [MM_W-1:0]          miss_run_inc_s;
  logic                     locked_r;
  logic                     error_r;
  logic                     err_hit_s;
  logic                     data_match_s;
  logic                     data_ones_s;
  logic [LFSR_MAX_BITS-1:0] data_ext_s;
  logic [LFSR_MAX_BITS-1:0] exp_ext_s;
  logic [LFSR_MAX_BITS-1:0] seed_full_s;
  logic [LFSR_MAX_BITS-1:0] free_full_s;
  logic [NUM_BITS-1:0]      seed_next_s;
  logic [NUM_BITS-1:0]      free_next_s;

  // Successor words: from received data (seeding) and from the prediction (free-run).
  always_comb begin
    data_ext_s                 = '0;
    exp_ext_s                  = '0;
    data_ext_s[NUM_BITS-1:0]   = i_Data;
    exp_ext_s[NUM_BITS-1:0]    = expected_r;
    seed_full_s                = lfsr_next(NUM_BITS, data_ext_s);
    free_full_s                = lfsr_next(NUM_BITS, exp_ext_s);
  end

  assign seed_next_s     = seed_full_s[NUM_BITS-1:0];
  assign free_next_s     = free_full_s[NUM_BITS-1:0];
  assign data_match_s    = (i_Data == expected_r);
  assign data_ones_s     = (i_Data == '1);
  assign match_run_inc_s = match_run_r + MR_W'(1'b1);
  assign miss_run_inc_s  = miss_run_r + MM_W'(1'b1);

  // State register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; an all-ones word can never seed, so a failed VERIFY on it falls back to HUNT.
  always_comb begin
    state_nxt_s = state_r;
    if (i_Data_DV) begin
      case (state_r)
        HUNT: begin
          if (!data_ones_s) begin
            state_nxt_s = VERIFY;
          end else begin
            state_nxt_s = HUNT;
          end
        end
        VERIFY: begin
          if (data_match_s) begin
            state_nxt_s = (match_run_inc_s == LOCK_TGT) ? LOCKED : VERIFY;
          end else if (data_ones_s) begin
            state_nxt_s = HUNT;
          end else begin
            state_nxt_s = VERIFY;
          end
        end
        LOCKED: begin
          if (!data_match_s && (miss_run_inc_s == UNLOCK_TGT)) begin
            state_nxt_s = HUNT;
          end else begin
            state_nxt_s = LOCKED;
          end
        end
        default: state_nxt_s = HUNT;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Datapath next values: prediction, run counters and the mismatch strobe.
  always_comb begin
    expected_nxt_s  = expected_r;
    match_run_nxt_s = match_run_r;
    miss_run_nxt_s  = miss_run_r;
    err_hit_s       = 1'b0;
    if (i_Data_DV) begin
      case (state_r)
        HUNT, VERIFY: begin
          miss_run_nxt_s = '0;
          if ((state_r == VERIFY) && data_match_s) begin
            expected_nxt_s  = seed_next_s;
            match_run_nxt_s = match_run_inc_s;
          end else if (!data_ones_s) begin
            expected_nxt_s  = seed_next_s;
            match_run_nxt_s = '0;
          end else begin
            match_run_nxt_s = '0;
          end
        end
        LOCKED: begin
          expected_nxt_s  = free_next_s;
          match_run_nxt_s = '0;
          if (!data_match_s) begin
            err_hit_s      = 1'b1;
            miss_run_nxt_s = miss_run_inc_s;
          end else begin
            miss_run_nxt_s = '0;
          end
        end
        default: begin
          expected_nxt_s  = '0;
          match_run_nxt_s = '0;
          miss_run_nxt_s  = '0;
        end
      endcase
    end else begin
      err_hit_s = 1'b0;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      expected_r  <= '0;
      match_run_r <= '0;
      miss_run_r  <= '0;
      locked_r    <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      expected_r  <= expected_nxt_s;
      match_run_r <= match_run_nxt_s;
      miss_run_r  <= miss_run_nxt_s;
      locked_r    <= (state_nxt_s == LOCKED);
      error_r     <= err_hit_s;
    end
  end

  lfsr_chk_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Clr   (i_Clr_Count),
    .i_Inc   (err_hit_s),
    .o_Count (o_Err_Count)
  );

  assign o_Locked   = locked_r;
  assign o_Error    = error_r;
  assign o_Expected = expected_r;

`ifdef LFSR_CHK_PERIOD_EN
  logic [NUM_BITS-1:0] lock_word_r;
  logic [NUM_BITS-1:0] word_count_r;
  logic                period_done_r;

  // Period tracking: capture the prediction at lock entry and flag its return.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || (state_nxt_s == HUNT)) begin
      lock_word_r   <= '0;
      word_count_r  <= '0;
      period_done_r <= 1'b0;
    end else if ((state_r == VERIFY) && (state_nxt_s == LOCKED)) begin
      lock_word_r   <= expected_nxt_s;
      word_count_r  <= '0;
      period_done_r <= 1'b0;
    end else if ((state_r == LOCKED) && i_Data_DV) begin
      word_count_r  <= word_count_r + NUM_BITS'(1'b1);
      period_done_r <= (expected_nxt_s == lock_word_r);
    end else begin
      period_done_r <= 1'b0;
    end
  end

  assign o_Word_Count  = word_count_r;
  assign o_Period_Done = period_done_r;
`endif

endmodule
